multicycle_controller: RTL and testbench

- Next-generation main controller for the multi-cycle MIPS core; replaces the single-cycle combinational decoder.
- A state machine sequences each instruction through IF/ID/EXE/MEM/WB and issues per-state datapath strobes (PCWrite, IRWrite, RegWrite, MemWrite).
- Handshakes with instruction and data memories, with a wait timeout.
- Decodes opcode/func from the instruction register; sits between the IR and the datapath muxes, ALU and register file.

---
 rtl/multicycle_controller.sv | 219 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS main controller: IF/ID/EXE/MEM/WB sequencer with memory wait timeout.
// Optional retire counter enabled by defining MC_RETIRE_CNT_EN.
module multicycle_controller #(
    parameter int ALUOP_W        = 3,
    parameter int EXTOP_W        = 2,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         OpCode,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               ALUSrc,
    output logic               Mem_to_Reg,
    output logic               nPC_sel,
    output logic               J,
    output logic               jal,
    output logic               jr,
    output logic [1:0]         RegDst,
    output logic [EXTOP_W-1:0] Extop,
    output logic [ALUOP_W-1:0] ALUop,
    output logic               illegal,
    output logic               bus_err,
    output logic [2:0]         state,
    output logic [31:0]        retire_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EXE  = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_t           cur, nxt;
    logic [CNT_W-1:0] cnt;

    logic op_r, is_addu, is_subu, is_slt, is_jr, is_rtype;
    logic is_j, is_jal, is_ori, is_lui, is_addi, is_lw, is_sw, is_beq;
    logic legal, waiting, timeout;

    assign op_r     = (OpCode == 6'b000000);
    assign is_addu  = op_r && (func == 6'b100001);
    assign is_subu  = op_r && (func == 6'b100011);
    assign is_slt   = op_r && (func == 6'b101010);
    assign is_jr    = op_r && (func == 6'b001000);
    assign is_rtype = is_addu || is_subu || is_slt;
    assign is_j     = (OpCode == 6'b000010);
    assign is_jal   = (OpCode == 6'b000011);
    assign is_ori   = (OpCode == 6'b001101);
    assign is_lui   = (OpCode == 6'b001111);
    assign is_addi  = (OpCode == 6'b001000) || (OpCode == 6'b001001);
    assign is_lw    = (OpCode == 6'b100011);
    assign is_sw    = (OpCode == 6'b101011);
    assign is_beq   = (OpCode == 6'b000100);

    assign legal = is_rtype || is_jr || is_j || is_jal || is_ori || is_lui
                || is_addi || is_lw || is_sw || is_beq;

    // Ready lines only matter in the two wait states.
    assign waiting = (cur == S_IF  && !imem_ready)
                  || (cur == S_MEM && !dmem_ready);
    assign timeout = waiting && (cnt == LIMIT);

    assign state = cur;

    always_comb begin
        nxt        = cur;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        ALUSrc     = 1'b0;
        Mem_to_Reg = 1'b0;
        nPC_sel    = 1'b0;
        J          = 1'b0;
        jal        = 1'b0;
        jr         = 1'b0;
        RegDst     = 2'b00;
        Extop      = '0;
        ALUop      = '0;
        illegal    = 1'b0;
        bus_err    = 1'b0;

        // ALU operand/op selection stays stable from EXE through WB.
        if (cur == S_EXE || cur == S_MEM || cur == S_WB) begin
            unique case (1'b1)
                is_rtype: ALUop = is_subu ? ALUOP_W'(1)
                                : is_slt  ? ALUOP_W'(3) : ALUOP_W'(0);
                is_ori: begin
                    ALUSrc = 1'b1;
                    ALUop  = ALUOP_W'(2);
                end
                is_lui: begin
                    ALUSrc = 1'b1;
                    Extop  = EXTOP_W'(2);
                end
                (is_addi || is_lw || is_sw): begin
                    ALUSrc = 1'b1;
                    Extop  = EXTOP_W'(1);
                end
                is_beq:  ALUop = ALUOP_W'(1);
                default: ALUop = '0;
            endcase
        end

        unique case (cur)
            S_IDLE: nxt = S_IF;
            S_IF: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    nxt     = S_ID;
                end else if (timeout) begin
                    bus_err = 1'b1;
                    nxt     = S_IF;
                end
            end
            S_ID: begin
                if (is_j) begin
                    J       = 1'b1;
                    PCWrite = 1'b1;
                    nxt     = S_IF;
                end else if (is_jal) begin
                    jal      = 1'b1;
                    RegDst   = 2'b10;
                    RegWrite = 1'b1;
                    PCWrite  = 1'b1;
                    nxt      = S_IF;
                end else if (is_jr) begin
                    jr      = 1'b1;
                    nPC_sel = 1'b1;
                    PCWrite = 1'b1;
                    nxt     = S_IF;
                end else if (legal) begin
                    nxt = S_EXE;
                end else begin
                    illegal = 1'b1;
                    nxt     = S_IF;
                end
            end
            S_EXE: begin
                if (is_rtype) begin
                    RegDst = 2'b01;
                    nxt    = S_WB;
                end else if (is_ori || is_lui || is_addi) begin
                    nxt = S_WB;
                end else if (is_lw || is_sw) begin
                    nxt = S_MEM;
                end else begin
                    nPC_sel = is_beq;
                    PCWrite = is_beq && zero;
                    nxt     = S_IF;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                MemWrite = is_sw && !timeout;
                if (dmem_ready) begin
                    nxt = is_lw ? S_WB : S_IF;
                end else if (timeout) begin
                    bus_err = 1'b1;
                    nxt     = S_IF;
                end
            end
            S_WB: begin
                RegWrite   = 1'b1;
                Mem_to_Reg = is_lw;
                RegDst     = is_rtype ? 2'b01 : 2'b00;
                nxt        = S_IF;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= S_IDLE;
            cnt <= '0;
        end else begin
            cur <= nxt;
            cnt <= (waiting && !timeout) ? cnt + CNT_W'(1) : '0;
        end
    end

`ifdef MC_RETIRE_CNT_EN
    logic [31:0] rcnt;
    logic        done;

    assign done = (nxt == S_IF) && !illegal && !bus_err
               && (cur == S_ID || cur == S_EXE || cur == S_MEM || cur == S_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rcnt <= '0;
        else if (done) rcnt <= rcnt + 32'd1;
    end

    assign retire_cnt = rcnt;
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
// Retire counter expectations follow MC_RETIRE_CNT_EN.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  OpCode = 6'd0;
    logic [5:0]  func = 6'd0;
    logic        zero = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, dmem_req, IRWrite, PCWrite, RegWrite, MemWrite;
    logic        ALUSrc, Mem_to_Reg, nPC_sel, J, jal, jr, illegal, bus_err;
    logic [1:0]  RegDst;
    logic [1:0]  Extop;
    logic [2:0]  ALUop;
    logic [2:0]  state;
    logic [31:0] retire_cnt;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .func(func),
        .zero(zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .ALUSrc(ALUSrc), .Mem_to_Reg(Mem_to_Reg), .nPC_sel(nPC_sel),
        .J(J), .jal(jal), .jr(jr), .RegDst(RegDst), .Extop(Extop),
        .ALUop(ALUop), .illegal(illegal), .bus_err(bus_err),
        .state(state), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

`ifdef MC_RETIRE_CNT_EN
    localparam int RET_INC = 1;
`else
    localparam int RET_INC = 0;
`endif

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_ret = 32'd0;
    logic [20:0] outs;
    logic [15:0] obs;

    assign outs = {imem_req, dmem_req, IRWrite, PCWrite, RegWrite, MemWrite,
                   ALUSrc, Mem_to_Reg, nPC_sel, J, jal, jr, RegDst, Extop,
                   ALUop, illegal, bus_err};

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_ret(input string name);
        total++;
        if (retire_cnt !== exp_ret) begin
            bad++;
            $display("FAIL %s retire got=%0d req=%0d", name, retire_cnt, exp_ret);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if (state !== 3'd0 || outs !== 21'd0) begin
            bad++;
            $display("FAIL reset state=%0d outs=%h req 0/0", state, outs);
        end
        chk_ret("reset");
        @(negedge clk);
        rst_n = 1'b1;
        imem_ready = 1'b1;
        OpCode = 6'b000000;
        func = 6'b100001;
        total++;
        if (state !== 3'd0 || outs !== 21'd0) begin
            bad++;
            $display("FAIL idle state=%0d outs=%h req 0/0", state, outs);
        end
        step();
    endtask

    task automatic test_addu();
        obs = {10'd0, state, imem_req, IRWrite, PCWrite};
        total++;
        if (obs !== {10'd0, 3'd1, 3'b111}) begin
            bad++;
            $display("FAIL addu_if got=%h req=%h", obs, {10'd0, 3'd1, 3'b111});
        end
        step();
        obs = {10'd0, state, PCWrite, RegWrite, MemWrite};
        total++;
        if (obs !== {10'd0, 3'd2, 3'b000}) begin
            bad++;
            $display("FAIL addu_id got=%h", obs);
        end
        step();
        obs = {6'd0, state, RegDst, ALUop, ALUSrc, RegWrite};
        total++;
        if (obs !== {6'd0, 3'd3, 2'b01, 3'b000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL addu_exe got=%h req=%h", obs,
                     {6'd0, 3'd3, 2'b01, 3'b000, 1'b0, 1'b0});
        end
        step();
        obs = {8'd0, state, RegWrite, RegDst, MemWrite, PCWrite};
        total++;
        if (obs !== {8'd0, 3'd5, 1'b1, 2'b01, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL addu_wb got=%h", obs);
        end
        step();
        exp_ret = exp_ret + 32'(RET_INC);
        total++;
        if (state !== 3'd1) begin
            bad++;
            $display("FAIL addu_back got=%0d req=1", state);
        end
        chk_ret("addu");
    endtask

    task automatic test_lw();
        OpCode = 6'b100011;
        dmem_ready = 1'b0;
        step();
        step();
        obs = {8'd0, state, ALUSrc, Extop, ALUop};
        total++;
        if (obs !== {8'd0, 3'd3, 1'b1, 2'b01, 3'b000}) begin
            bad++;
            $display("FAIL lw_exe got=%h", obs);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_ready = 1'b1;
            #1;
            obs = {11'd0, state, dmem_req, MemWrite};
            total++;
            if (obs !== {11'd0, 3'd4, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL lw_mem%0d got=%h", i, obs);
            end
            step();
        end
        dmem_ready = 1'b0;
        obs = {9'd0, state, RegWrite, Mem_to_Reg, RegDst};
        total++;
        if (obs !== {9'd0, 3'd5, 1'b1, 1'b1, 2'b00}) begin
            bad++;
            $display("FAIL lw_wb got=%h", obs);
        end
        step();
        exp_ret = exp_ret + 32'(RET_INC);
        chk_ret("lw");
    endtask

    task automatic test_beq();
        OpCode = 6'b000100;
        for (int k = 0; k < 2; k++) begin
            zero = (k == 0);
            step();
            step();
            obs = {8'd0, state, PCWrite, nPC_sel, ALUop};
            total++;
            if (obs !== {8'd0, 3'd3, (k == 0), 1'b1, 3'b001}) begin
                bad++;
                $display("FAIL beq_exe%0d got=%h", k, obs);
            end
            step();
            total++;
            if (state !== 3'd1) begin
                bad++;
                $display("FAIL beq_back%0d got=%0d req=1", k, state);
            end
        end
        zero = 1'b0;
        exp_ret = exp_ret + 32'(2 * RET_INC);
        chk_ret("beq");
    endtask

    task automatic test_jal();
        OpCode = 6'b000011;
        step();
        obs = {8'd0, state, RegDst, RegWrite, PCWrite, jal};
        total++;
        if (obs !== {8'd0, 3'd2, 2'b10, 1'b1, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL jal_id got=%h", obs);
        end
        step();
        exp_ret = exp_ret + 32'(RET_INC);
        total++;
        if (state !== 3'd1) begin
            bad++;
            $display("FAIL jal_back got=%0d req=1", state);
        end
        chk_ret("jal");
    endtask

    task automatic test_illegal();
        OpCode = 6'b111111;
        step();
        obs = {9'd0, state, illegal, RegWrite, MemWrite, PCWrite};
        total++;
        if (obs !== {9'd0, 3'd2, 4'b1000}) begin
            bad++;
            $display("FAIL ill_id got=%h", obs);
        end
        step();
        obs = {12'd0, state, illegal};
        total++;
        if (obs !== {12'd0, 3'd1, 1'b0}) begin
            bad++;
            $display("FAIL ill_back got=%h", obs);
        end
        chk_ret("illegal");
    endtask

    task automatic test_ori();
        OpCode = 6'b001101;
        step();
        step();
        obs = {8'd0, state, ALUSrc, Extop, ALUop};
        total++;
        if (obs !== {8'd0, 3'd3, 1'b1, 2'b00, 3'b010}) begin
            bad++;
            $display("FAIL ori_exe got=%h", obs);
        end
        step();
        step();
        exp_ret = exp_ret + 32'(RET_INC);
        chk_ret("ori");
    endtask

    task automatic test_if_timeout();
        imem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            total++;
            if (state !== 3'd1 || bus_err !== 1'b0) begin
                bad++;
                $display("FAIL if_wait%0d st=%0d be=%b", i, state, bus_err);
            end
            step();
        end
        obs = {10'd0, state, bus_err, IRWrite, PCWrite};
        total++;
        if (obs !== {10'd0, 3'd1, 3'b100}) begin
            bad++;
            $display("FAIL if_timeout got=%h", obs);
        end
        step();
        for (int i = 0; i < 15; i++) begin
            total++;
            if (bus_err !== 1'b0) begin
                bad++;
                $display("FAIL if_rewait%0d be=%b req=0", i, bus_err);
            end
            step();
        end
        imem_ready = 1'b1;
        OpCode = 6'b101011;
        #1;
        obs = {13'd0, bus_err, IRWrite, PCWrite};
        total++;
        if (obs !== {13'd0, 3'b011}) begin
            bad++;
            $display("FAIL if_edge got=%h req=3", obs);
        end
        chk_ret("if_timeout");
    endtask

    task automatic test_sw_timeout();
        dmem_ready = 1'b0;
        step();
        step();
        step();
        for (int i = 0; i < 15; i++) begin
            obs = {10'd0, state, MemWrite, dmem_req, bus_err};
            total++;
            if (obs !== {10'd0, 3'd4, 3'b110}) begin
                bad++;
                $display("FAIL sw_wait%0d got=%h", i, obs);
            end
            step();
        end
        obs = {10'd0, state, MemWrite, dmem_req, bus_err};
        total++;
        if (obs !== {10'd0, 3'd4, 3'b011}) begin
            bad++;
            $display("FAIL sw_timeout got=%h", obs);
        end
        step();
        obs = {11'd0, state, bus_err, MemWrite};
        total++;
        if (obs !== {11'd0, 3'd1, 2'b00}) begin
            bad++;
            $display("FAIL sw_abort got=%h", obs);
        end
        chk_ret("sw_timeout");
        step();
        step();
        step();
        for (int i = 0; i < 15; i++) step();
        dmem_ready = 1'b1;
        #1;
        obs = {11'd0, state, bus_err, MemWrite};
        total++;
        if (obs !== {11'd0, 3'd4, 2'b01}) begin
            bad++;
            $display("FAIL sw_edge got=%h", obs);
        end
        step();
        dmem_ready = 1'b0;
        exp_ret = exp_ret + 32'(RET_INC);
        total++;
        if (state !== 3'd1) begin
            bad++;
            $display("FAIL sw_done got=%0d req=1", state);
        end
        chk_ret("sw_edge");
    endtask

    task automatic test_reset_mid();
        step();
        step();
        step();
        total++;
        if (state !== 3'd4 || MemWrite !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre st=%0d mw=%b", state, MemWrite);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_ret = 32'd0;
        total++;
        if (state !== 3'd0 || outs !== 21'd0) begin
            bad++;
            $display("FAIL mid_reset st=%0d outs=%h req 0/0", state, outs);
        end
        chk_ret("mid_reset");
        step();
        total++;
        if (state !== 3'd0 || outs !== 21'd0) begin
            bad++;
            $display("FAIL mid_hold st=%0d outs=%h", state, outs);
        end
        rst_n = 1'b1;
        step();
        total++;
        if (state !== 3'd1) begin
            bad++;
            $display("FAIL mid_restart got=%0d req=1", state);
        end
    endtask

    initial begin
        test_reset();
        test_addu();
        test_lw();
        test_beq();
        test_jal();
        test_illegal();
        test_ori();
        test_if_timeout();
        test_sw_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
